// File: rtl/module_seg_scan.sv
`default_nettype none
// ============================================================================
//  Module      : module_seg_scan
//  Description : Time-multiplexed driver for NDIG common-bus 7-segment digits.
//                Scans one digit per slot with a dead-time gap at the start of
//                each slot. Supports per-digit decimal points, leading-zero
//                blanking and tear-free frame updates through a shadow register.
//  Revision    : 1.0 - initial release
// ============================================================================
module module_seg_scan #(
  parameter int NDIG       = 4,
  parameter int CLK_HZ     = 27_000_000,
  parameter int DIGIT_HZ   = 4_000,
  parameter int BLANK_CYC  = 64,
  parameter int SEG_ACT_HI = 1,
  parameter int AN_ACT_HI  = 0,
  parameter int LZ_BLANK   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [4*NDIG-1:0] val,
  input  logic [NDIG-1:0]   dp_in,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [NDIG-1:0]   an,
  output logic              frame
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int DIV = CLK_HZ / DIGIT_HZ;
  // Guards keep the widths sane when parameters are illegal; the checks
  // below stop elaboration in that case anyway.
  localparam int CW  = (DIV > 2)  ? $clog2(DIV)  : 2;
  localparam int IW  = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] BLK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

  localparam logic [6:0]      SEG_OFF = (SEG_ACT_HI != 0) ? 7'h00 : 7'h7F;
  localparam logic            DP_OFF  = (SEG_ACT_HI != 0) ? 1'b0  : 1'b1;
  localparam logic [NDIG-1:0] AN_OFF  = (AN_ACT_HI  != 0) ? {NDIG{1'b0}} : {NDIG{1'b1}};

  // --------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // --------------------------------------------------------------------------
  if (NDIG < 2 || NDIG > 8) begin : g_chk_ndig
    $error("module_seg_scan: NDIG must be in 2..8");
  end
  if (DIV < 4) begin : g_chk_div
    $error("module_seg_scan: CLK_HZ/DIGIT_HZ must be at least 4");
  end
  if (BLANK_CYC < 0 || BLANK_CYC >= DIV) begin : g_chk_blank
    $error("module_seg_scan: BLANK_CYC must be in 0..DIV-1");
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  // With no dead time a slot starts directly in DRIVE.
  localparam state_t ST_START = (BLANK_CYC == 0) ? ST_DRIVE : ST_BLANK;

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [4*NDIG-1:0]   shadow;
  logic [NDIG-1:0]     shadow_dp;
  logic [4*NDIG-1:0]   disp;
  logic [NDIG-1:0]     disp_dp;
  logic                pending;

  state_t              nxt_state;
  logic [CW-1:0]       nxt_cnt;
  logic [IW-1:0]       nxt_idx;
  logic                boundary;
  logic [4*NDIG-1:0]   nxt_disp;
  logic [NDIG-1:0]     nxt_disp_dp;

  logic [NDIG-1:0]     zero_run;
  logic                run;
  logic [3:0]          nib;
  logic                dp_bit;
  logic                blank_dig;
  logic [NDIG-1:0]     an_one;
  logic [6:0]          hex_seg;

  // Hex nibble to {a,b,c,d,e,f,g}, active-high view
  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b1111110;
      4'h1:    s = 7'b0110000;
      4'h2:    s = 7'b1101101;
      4'h3:    s = 7'b1111001;
      4'h4:    s = 7'b0110011;
      4'h5:    s = 7'b1011011;
      4'h6:    s = 7'b1011111;
      4'h7:    s = 7'b1110000;
      4'h8:    s = 7'b1111111;
      4'h9:    s = 7'b1111011;
      4'hA:    s = 7'b1110111;
      4'hB:    s = 7'b0011111;
      4'hC:    s = 7'b1001110;
      4'hD:    s = 7'b0111101;
      4'hE:    s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  // Next-state of the scan sequencer; flags the frame boundary cycle
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_idx   = idx;
    boundary  = 1'b0;
    if (!en) begin
      nxt_state = ST_OFF;
      nxt_cnt   = '0;
      nxt_idx   = '0;
    end else begin
      case (state)
        ST_OFF: begin
          nxt_state = ST_START;
          nxt_cnt   = '0;
          nxt_idx   = '0;
          boundary  = 1'b1;
        end
        default: begin
          if (cnt == CNT_LAST) begin
            nxt_cnt   = '0;
            nxt_state = ST_START;
            if (idx == IDX_LAST) begin
              nxt_idx  = '0;
              boundary = 1'b1;
            end else begin
              nxt_idx = idx + 1'b1;
            end
          end else begin
            nxt_cnt = cnt + 1'b1;
            if (state == ST_BLANK && cnt == BLK_LAST) begin
              nxt_state = ST_DRIVE;
            end
          end
        end
      endcase
    end
  end

  // Display register contents for the coming cycle (shadow moves only at a boundary)
  always_comb begin
    nxt_disp    = disp;
    nxt_disp_dp = disp_dp;
    if (boundary && pending) begin
      nxt_disp    = shadow;
      nxt_disp_dp = shadow_dp;
    end
  end

  // zero_run[k] = nibbles k..NDIG-1 of the upcoming display word are all zero
  always_comb begin
    zero_run = '0;
    run      = 1'b1;
    for (int k = NDIG - 1; k >= 0; k--) begin
      run         = run & (nxt_disp[4*k +: 4] == 4'h0);
      zero_run[k] = run;
    end
  end

  // Select the digit addressed by the upcoming index and decode it
  always_comb begin
    nib       = 4'h0;
    dp_bit    = 1'b0;
    blank_dig = 1'b0;
    an_one    = '0;
    for (int k = 0; k < NDIG; k++) begin
      if (nxt_idx == IW'(k)) begin
        nib       = nxt_disp[4*k +: 4];
        dp_bit    = nxt_disp_dp[k];
        blank_dig = (LZ_BLANK != 0) && (k != 0) && zero_run[k];
        an_one[k] = 1'b1;
      end
    end
    hex_seg = hex7(nib);
  end

  // Sequencer, shadow/display registers and registered pin drivers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_OFF;
      cnt       <= '0;
      idx       <= '0;
      shadow    <= '0;
      shadow_dp <= '0;
      disp      <= '0;
      disp_dp   <= '0;
      pending   <= 1'b0;
      seg       <= SEG_OFF;
      dp        <= DP_OFF;
      an        <= AN_OFF;
      frame     <= 1'b0;
    end else begin
      state   <= nxt_state;
      cnt     <= nxt_cnt;
      idx     <= nxt_idx;
      disp    <= nxt_disp;
      disp_dp <= nxt_disp_dp;
      // A load in the boundary cycle itself keeps pending set for the next frame.
      if (load) begin
        shadow    <= val;
        shadow_dp <= dp_in;
        pending   <= 1'b1;
      end else if (boundary) begin
        pending <= 1'b0;
      end
      frame <= boundary;
      if (nxt_state == ST_DRIVE) begin
        an  <= (AN_ACT_HI != 0) ? an_one : ~an_one;
        seg <= blank_dig ? SEG_OFF : ((SEG_ACT_HI != 0) ? hex_seg : ~hex_seg);
        dp  <= (SEG_ACT_HI != 0) ? dp_bit : ~dp_bit;
      end else begin
        an  <= AN_OFF;
        seg <= SEG_OFF;
        dp  <= DP_OFF;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_module_seg_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_module_seg_scan
//  Description : Directed self-checking bench for module_seg_scan with
//                NDIG=4, DIV=10, BLANK_CYC=2, active-high segments and
//                active-low anodes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_module_seg_scan;

  logic        clk;
  logic        rst;
  logic        en;
  logic        load;
  logic [15:0] val;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame;

  int n_pass;
  int n_total;

  localparam logic [6:0] S_0 = 7'b1111110;
  localparam logic [6:0] S_1 = 7'b0110000;
  localparam logic [6:0] S_2 = 7'b1101101;
  localparam logic [6:0] S_5 = 7'b1011011;
  localparam logic [6:0] S_A = 7'b1110111;
  localparam logic [6:0] S_F = 7'b1000111;
  localparam logic [6:0] S_X = 7'b0000000;
  localparam logic [12:0] DARK = {1'b0, 4'b1111, 7'b0000000, 1'b0};

  module_seg_scan #(
    .NDIG(4), .CLK_HZ(100), .DIGIT_HZ(10), .BLANK_CYC(2),
    .SEG_ACT_HI(1), .AN_ACT_HI(0), .LZ_BLANK(1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .val(val), .dp_in(dp_in),
    .seg(seg), .dp(dp), .an(an), .frame(frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [12:0] got;
    rst = 1'b1; en = 1'b0; load = 1'b0; val = '0; dp_in = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      got = {frame, an, seg, dp};
      n_total++;
      if (got !== DARK) $display("FAIL reset cyc=%0d got=%b exp=%b", i, got, DARK);
      else n_pass++;
    end
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      got = {frame, an, seg, dp};
      n_total++;
      if (got !== DARK) $display("FAIL idle_off cyc=%0d got=%b exp=%b", i, got, DARK);
      else n_pass++;
    end
  endtask

  task automatic test_scan();
    logic [6:0]  segs [4];
    logic [3:0]  oh;
    logic [12:0] got, exp_v;
    segs[0] = S_F; segs[1] = S_A; segs[2] = S_2; segs[3] = S_1;
    load = 1'b1; val = 16'h12AF; dp_in = 4'b0000;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 10; c++) begin
        if (!(d == 0 && c == 0)) tick();
        oh    = 4'b0001 << d;
        exp_v = {(d == 0 && c == 0), (c < 2) ? 4'b1111 : ~oh, (c < 2) ? S_X : segs[d], 1'b0};
        got   = {frame, an, seg, dp};
        n_total++;
        if (got !== exp_v) $display("FAIL scan d=%0d c=%0d got=%b exp=%b", d, c, got, exp_v);
        else n_pass++;
      end
    end
    tick();
    n_total++;
    if (frame !== 1'b1) $display("FAIL scan_next_frame got=%b exp=1", frame);
    else n_pass++;
  endtask

  task automatic test_lz_blank();
    logic [6:0]  segs [4];
    logic [3:0]  dps;
    logic [3:0]  oh;
    logic [12:0] got, exp_v;
    segs[0] = S_0; segs[1] = S_5; segs[2] = S_X; segs[3] = S_X;
    dps = 4'b0100;
    en = 1'b0; load = 1'b1; val = 16'h0050; dp_in = 4'b0100;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 10; c++) begin
        if (!(d == 0 && c == 0)) tick();
        oh    = 4'b0001 << d;
        exp_v = {(d == 0 && c == 0), (c < 2) ? 4'b1111 : ~oh, (c < 2) ? S_X : segs[d],
                 (c < 2) ? 1'b0 : dps[d]};
        got   = {frame, an, seg, dp};
        n_total++;
        if (got !== exp_v) $display("FAIL lz d=%0d c=%0d got=%b exp=%b", d, c, got, exp_v);
        else n_pass++;
      end
    end
  endtask

  task automatic test_midframe_load();
    logic [6:0]  segs [4];
    logic [3:0]  dps;
    logic [3:0]  oh;
    logic [12:0] got, exp_v;
    segs[0] = S_0; segs[1] = S_5; segs[2] = S_X; segs[3] = S_X;
    dps = 4'b0100;
    tick();
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 10; c++) begin
        if (!(d == 0 && c == 0)) tick();
        load = 1'b0;
        if (d == 1 && c == 3) begin load = 1'b1; val = 16'h1111; dp_in = 4'b0000; end
        if (d == 2 && c == 5) begin load = 1'b1; val = 16'h2222; dp_in = 4'b0000; end
        oh    = 4'b0001 << d;
        exp_v = {(d == 0 && c == 0), (c < 2) ? 4'b1111 : ~oh, (c < 2) ? S_X : segs[d],
                 (c < 2) ? 1'b0 : dps[d]};
        got   = {frame, an, seg, dp};
        n_total++;
        if (got !== exp_v) $display("FAIL hold_frame d=%0d c=%0d got=%b exp=%b", d, c, got, exp_v);
        else n_pass++;
      end
    end
    load = 1'b0;
    tick();
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 10; c++) begin
        if (!(d == 0 && c == 0)) tick();
        oh    = 4'b0001 << d;
        exp_v = {(d == 0 && c == 0), (c < 2) ? 4'b1111 : ~oh, (c < 2) ? S_X : S_2, 1'b0};
        got   = {frame, an, seg, dp};
        n_total++;
        if (got !== exp_v) $display("FAIL last_load d=%0d c=%0d got=%b exp=%b", d, c, got, exp_v);
        else n_pass++;
      end
    end
  endtask

  task automatic test_en_toggle();
    logic [12:0] got, exp_v;
    tick();
    for (int i = 0; i < 24; i++) tick();
    exp_v = {1'b0, 4'b1011, S_2, 1'b0};
    got   = {frame, an, seg, dp};
    n_total++;
    if (got !== exp_v) $display("FAIL en_pre_digit2 got=%b exp=%b", got, exp_v);
    else n_pass++;
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      got = {frame, an, seg, dp};
      n_total++;
      if (got !== DARK) $display("FAIL en_off cyc=%0d got=%b exp=%b", i, got, DARK);
      else n_pass++;
    end
    en = 1'b1;
    tick();
    exp_v = {1'b1, 4'b1111, S_X, 1'b0};
    got   = {frame, an, seg, dp};
    n_total++;
    if (got !== exp_v) $display("FAIL en_restart_frame got=%b exp=%b", got, exp_v);
    else n_pass++;
    tick();
    tick();
    exp_v = {1'b0, 4'b1110, S_2, 1'b0};
    got   = {frame, an, seg, dp};
    n_total++;
    if (got !== exp_v) $display("FAIL en_restart_digit0 got=%b exp=%b", got, exp_v);
    else n_pass++;
  endtask

  task automatic test_rst_mid_scan();
    logic [3:0]  oh;
    logic [12:0] got, exp_v;
    for (int i = 0; i < 12; i++) tick();
    exp_v = {1'b0, 4'b1101, S_2, 1'b0};
    got   = {frame, an, seg, dp};
    n_total++;
    if (got !== exp_v) $display("FAIL rst_pre_digit1 got=%b exp=%b", got, exp_v);
    else n_pass++;
    rst = 1'b1; load = 1'b1; val = 16'h9999; dp_in = 4'b1111;
    tick();
    got = {frame, an, seg, dp};
    n_total++;
    if (got !== DARK) $display("FAIL rst_dark got=%b exp=%b", got, DARK);
    else n_pass++;
    rst = 1'b0; load = 1'b0;
    tick();
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 10; c++) begin
        if (!(d == 0 && c == 0)) tick();
        oh    = 4'b0001 << d;
        exp_v = {(d == 0 && c == 0), (c < 2) ? 4'b1111 : ~oh,
                 (c < 2 || d != 0) ? S_X : S_0, 1'b0};
        got   = {frame, an, seg, dp};
        n_total++;
        if (got !== exp_v) $display("FAIL post_rst d=%0d c=%0d got=%b exp=%b", d, c, got, exp_v);
        else n_pass++;
      end
    end
    tick();
    tick();
    tick();
    exp_v = {1'b0, 4'b1110, S_0, 1'b0};
    got   = {frame, an, seg, dp};
    n_total++;
    if (got !== exp_v) $display("FAIL post_rst_frame2 got=%b exp=%b", got, exp_v);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst = 1'b1; en = 1'b0; load = 1'b0; val = '0; dp_in = '0;
    #1;
    test_reset();
    test_scan();
    test_lz_blank();
    test_midframe_load();
    test_en_toggle();
    test_rst_mid_scan();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
